scene_compositor: RTL and testbench



---
 rtl/game_pkg.sv | 18 +
 rtl/box_hit.sv | 32 +++
 rtl/scene_compositor.sv | 256 +++++++++++++++++++++++++
 tb/tb_scene_compositor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-state definitions: scene layer codes, ground geometry and bird
// tilt thresholds, common to the game logic and the scene compositor.
package game_pkg;

  typedef enum logic [2:0] {
    LAYER_BG     = 3'd0,
    LAYER_GROUND = 3'd1,
    LAYER_BODY   = 3'd2,
    LAYER_CAP    = 3'd3,
    LAYER_BIRD   = 3'd4
  } layer_e;

  localparam int STRIPE    = 28;   // ground stripe period, equals the stage_shift wrap
  localparam int GROUND_X  = 104;  // px below this is ground
  localparam int TILT_UP   = 10;   // angle above this selects the nose-up sprite
  localparam int TILT_DOWN = -30;  // angle below this selects the nose-down sprite

endpackage

// File: rtl/box_hit.sv
// One registered range test: checks LO <= diff < LO+LEN on a 17-bit signed
// difference and returns the offset from LO, clipped to zero outside the window.
module box_hit #(
  parameter int LO    = 0,
  parameter int LEN   = 1,
  parameter int OFF_W = 8
) (
  input  logic               clk,
  input  logic signed [16:0] diff,
  output logic               hit,
  output logic [OFF_W-1:0]   off
);

  localparam logic signed [17:0] LO_S  = 18'(LO);
  localparam logic signed [17:0] LEN_S = 18'(LEN);

  logic signed [17:0] rel;
  logic               in_rng;

  // Offset from the window start and the half-open window test
  always_comb begin
    rel    = $signed({diff[16], diff}) - LO_S;
    in_rng = !rel[17] && (rel < LEN_S);
  end

  // Register the verdict together with its clipped offset
  always_ff @(posedge clk) begin
    hit <= in_rng;
    off <= in_rng ? rel[OFF_W-1:0] : '0;
  end

endmodule

// File: rtl/scene_compositor.sv
// Resolves which scene layer is visible at each requested pixel from a
// per-frame snapshot of the game state, and emits the layer-local sprite
// address. Fixed three-stage pipeline, one pixel per clock, no backpressure.
module scene_compositor
  import game_pkg::*;
#(
  parameter int SNAP_DELAY = 2,
  parameter int BIRD_SX    = 34,
  parameter int BIRD_SY    = 48,
  parameter int PIPE_W     = 104,
  parameter int PIPE_GAP   = 188,
  parameter int CAP_LEN    = 24
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               new_frame,
  input  logic signed [15:0] stage_shift,
  input  logic [1:0]         bird_status,
  input  logic signed [15:0] bird_pos_x,
  input  logic signed [15:0] bird_pos_y,
  input  logic signed [7:0]  bird_angle,
  input  logic signed [15:0] pipe1_pos_x,
  input  logic signed [15:0] pipe2_pos_x,
  input  logic signed [15:0] pipe3_pos_x,
  input  logic signed [15:0] pipe1_pos_y,
  input  logic signed [15:0] pipe2_pos_y,
  input  logic signed [15:0] pipe3_pos_y,
  input  logic               pix_valid,
  input  logic signed [15:0] pix_x,
  input  logic signed [15:0] pix_y,
  output logic               out_valid,
  output logic signed [15:0] out_x,
  output logic signed [15:0] out_y,
  output logic [2:0]         layer,
  output logic [15:0]        sprite_addr
);

  // The gap and both caps form one window per pipe, starting at the far cap.
  localparam int WIN_LEN = PIPE_GAP + 2 * CAP_LEN;
  localparam int WIN_W   = $clog2(WIN_LEN);
  localparam int WIN_LO  = -PIPE_GAP - CAP_LEN;
  localparam logic [WIN_W-1:0] GAP_LO = WIN_W'(CAP_LEN);
  localparam logic [WIN_W-1:0] GAP_HI = WIN_W'(CAP_LEN + PIPE_GAP);
  localparam logic signed [15:0] GROUND_X_S  = 16'(GROUND_X);
  localparam logic signed [16:0] STRIPE_S    = 17'(STRIPE);
  localparam logic signed [7:0]  TILT_UP_S   = 8'(TILT_UP);
  localparam logic signed [7:0]  TILT_DOWN_S = 8'(TILT_DOWN);
  // The counter holds the cycles left after the load cycle, so capture lands
  // exactly SNAP_DELAY cycles after new_frame.
  localparam int CNT_W    = (SNAP_DELAY > 1) ? $clog2(SNAP_DELAY) : 1;
  localparam int CNT_LOAD = (SNAP_DELAY > 0) ? SNAP_DELAY - 1 : 0;

  function automatic logic signed [16:0] sdiff(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    return $signed({a[15], a}) - $signed({b[15], b});
  endfunction

  function automatic logic [1:0] tilt_of(input logic signed [7:0] ang);
    if (ang > TILT_UP_S)        return 2'd2;
    else if (ang < TILT_DOWN_S) return 2'd0;
    else                        return 2'd1;
  endfunction

  // Bounded compare-and-subtract modulo; the sum stays within a few periods.
  function automatic logic [4:0] stripe_mod(input logic signed [16:0] s);
    logic signed [16:0] r;
    r = s;
    for (int k = 0; k < 5; k++) begin
      if (r[16])              r = r + STRIPE_S;
      else if (r >= STRIPE_S) r = r - STRIPE_S;
    end
    return r[4:0];
  endfunction

  logic [CNT_W-1:0]   snap_cnt;
  logic               snap_run, snap_en;
  logic signed [15:0] snap_shift, snap_bird_x, snap_bird_y;
  logic [1:0]         snap_status;
  logic signed [7:0]  snap_angle;
  logic signed [15:0] snap_pipe_x [3];
  logic signed [15:0] snap_pipe_y [3];

  // Capture strobe: immediate for a zero delay, otherwise when the count expires
  always_comb snap_en = new_frame ? (SNAP_DELAY == 0) : (snap_run && snap_cnt == '0);

  // Delay counter; a fresh new_frame always restarts the count
  always_ff @(posedge clk) begin
    if (!rstn) begin
      snap_run <= 1'b0;
      snap_cnt <= '0;
    end else if (new_frame) begin
      snap_run <= (SNAP_DELAY != 0);
      snap_cnt <= CNT_W'(CNT_LOAD);
    end else if (snap_run) begin
      if (snap_cnt == '0) snap_run <= 1'b0;
      else                snap_cnt <= snap_cnt - CNT_W'(1);
    end
  end

  // Frame snapshot of every game input
  always_ff @(posedge clk) begin
    if (!rstn) begin
      snap_shift  <= '0;
      snap_status <= '0;
      snap_bird_x <= '0;
      snap_bird_y <= '0;
      snap_angle  <= '0;
      for (int i = 0; i < 3; i++) begin
        snap_pipe_x[i] <= '0;
        snap_pipe_y[i] <= '0;
      end
    end else if (snap_en) begin
      snap_shift     <= stage_shift;
      snap_status    <= bird_status;
      snap_bird_x    <= bird_pos_x;
      snap_bird_y    <= bird_pos_y;
      snap_angle     <= bird_angle;
      snap_pipe_x[0] <= pipe1_pos_x;
      snap_pipe_x[1] <= pipe2_pos_x;
      snap_pipe_x[2] <= pipe3_pos_x;
      snap_pipe_y[0] <= pipe1_pos_y;
      snap_pipe_y[1] <= pipe2_pos_y;
      snap_pipe_y[2] <= pipe3_pos_y;
    end
  end

  logic               vld_p1, vld_p2;
  logic signed [15:0] px_p1, py_p1, px_p2, py_p2;
  logic signed [16:0] dx_b_p1, dy_b_p1, gsum_p1;
  logic signed [16:0] dx_p1 [3];
  logic signed [16:0] dy_p1 [3];
  logic [1:0]         status_p1, status_p2, tilt_p1, tilt_p2;
  logic [4:0]         phase_p2;
  logic               ground_p2;

  // Valid shift chain; reset empties the pipeline
  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= pix_valid;
      vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: differences against the snapshot held this cycle ----
  always_ff @(posedge clk) begin
    px_p1     <= pix_x;
    py_p1     <= pix_y;
    dx_b_p1   <= sdiff(pix_x, snap_bird_x);
    dy_b_p1   <= sdiff(pix_y, snap_bird_y);
    for (int i = 0; i < 3; i++) begin
      dx_p1[i] <= sdiff(pix_x, snap_pipe_x[i]);
      dy_p1[i] <= sdiff(pix_y, snap_pipe_y[i]);
    end
    status_p1 <= snap_status;
    tilt_p1   <= tilt_of(snap_angle);
    gsum_p1   <= $signed({pix_y[15], pix_y}) + $signed({snap_shift[15], snap_shift});
  end

  // ---- stage 2: range tests ----
  logic                bird_x_hit_p2, bird_y_hit_p2;
  logic [5:0]          bird_x_off_p2, bird_y_off_p2;
  logic [2:0]          pin_hit_p2, win_hit_p2;
  logic [6:0]          pin_off_p2 [3];
  logic [WIN_W-1:0]    win_off_p2 [3];

  box_hit #(.LO(0), .LEN(BIRD_SX), .OFF_W(6)) u_bird_x (
    .clk(clk), .diff(dx_b_p1), .hit(bird_x_hit_p2), .off(bird_x_off_p2));
  box_hit #(.LO(0), .LEN(BIRD_SY), .OFF_W(6)) u_bird_y (
    .clk(clk), .diff(dy_b_p1), .hit(bird_y_hit_p2), .off(bird_y_off_p2));

  for (genvar g = 0; g < 3; g++) begin : g_pipe
    box_hit #(.LO(0), .LEN(PIPE_W), .OFF_W(7)) u_dy (
      .clk(clk), .diff(dy_p1[g]), .hit(pin_hit_p2[g]), .off(pin_off_p2[g]));
    box_hit #(.LO(WIN_LO), .LEN(WIN_LEN), .OFF_W(WIN_W)) u_dx (
      .clk(clk), .diff(dx_p1[g]), .hit(win_hit_p2[g]), .off(win_off_p2[g]));
  end

  // Side-band data travelling with the range tests
  always_ff @(posedge clk) begin
    px_p2     <= px_p1;
    py_p2     <= py_p1;
    status_p2 <= status_p1;
    tilt_p2   <= tilt_p1;
    phase_p2  <= stripe_mod(gsum_p1);
    ground_p2 <= (px_p1 < GROUND_X_S);
  end

  // ---- stage 3: layer priority and sprite address ----
  layer_e      layer_n;
  logic [15:0] addr_n;
  logic        cap_any, body_any;
  logic [6:0]  cap_dy, body_dy;
  logic [2:0]  gap_v, body_v, cap_v;

  // Bird over cap over body over ground; descending scan lets pipe 1 win ties
  always_comb begin
    layer_n  = LAYER_BG;
    addr_n   = '0;
    cap_any  = 1'b0;
    body_any = 1'b0;
    cap_dy   = '0;
    body_dy  = '0;
    gap_v    = '0;
    body_v   = '0;
    cap_v    = '0;
    for (int i = 2; i >= 0; i--) begin
      gap_v[i]  = win_hit_p2[i] && (win_off_p2[i] >= GAP_LO) && (win_off_p2[i] < GAP_HI);
      body_v[i] = pin_hit_p2[i] && !gap_v[i];
      cap_v[i]  = body_v[i] && win_hit_p2[i];
      if (cap_v[i]) begin
        cap_any = 1'b1;
        cap_dy  = pin_off_p2[i];
      end
      if (body_v[i]) begin
        body_any = 1'b1;
        body_dy  = pin_off_p2[i];
      end
    end
    if (bird_x_hit_p2 && bird_y_hit_p2) begin
      layer_n = LAYER_BIRD;
      addr_n  = {status_p2, tilt_p2, bird_x_off_p2, bird_y_off_p2};
    end else if (cap_any) begin
      layer_n = LAYER_CAP;
      addr_n  = {7'd0, 1'b1, 1'b0, cap_dy};
    end else if (body_any) begin
      layer_n = LAYER_BODY;
      addr_n  = {9'd0, body_dy};
    end else if (ground_p2) begin
      layer_n = LAYER_GROUND;
      addr_n  = {4'd0, px_p2[6:0], 5'd0} + {11'd0, phase_p2};
    end
  end

  // Output register; results hold across bubbles
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid   <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      layer       <= '0;
      sprite_addr <= '0;
    end else begin
      out_valid <= vld_p2;
      if (vld_p2) begin
        out_x       <= px_p2;
        out_y       <= py_p2;
        layer       <= layer_n;
        sprite_addr <= addr_n;
      end
    end
  end

endmodule

// File: tb/tb_scene_compositor.sv
// Directed bench for scene_compositor: snapshot timing, latency/throughput,
// layer priority, ground stripe phase, negative pipe origins and mid-stream reset.
module tb_scene_compositor;

  logic               clk = 1'b0;
  logic               rstn;
  logic               new_frame;
  logic signed [15:0] stage_shift;
  logic [1:0]         bird_status;
  logic signed [15:0] bird_pos_x, bird_pos_y;
  logic signed [7:0]  bird_angle;
  logic signed [15:0] pipe1_pos_x, pipe2_pos_x, pipe3_pos_x;
  logic signed [15:0] pipe1_pos_y, pipe2_pos_y, pipe3_pos_y;
  logic               pix_valid;
  logic signed [15:0] pix_x, pix_y;
  logic               out_valid;
  logic signed [15:0] out_x, out_y;
  logic [2:0]         layer;
  logic [15:0]        sprite_addr;

  int total = 0;
  int bad   = 0;
  int vld_seen;

  always #5 clk = ~clk;

  scene_compositor dut (
    .clk(clk), .rstn(rstn), .new_frame(new_frame), .stage_shift(stage_shift),
    .bird_status(bird_status), .bird_pos_x(bird_pos_x), .bird_pos_y(bird_pos_y),
    .bird_angle(bird_angle),
    .pipe1_pos_x(pipe1_pos_x), .pipe2_pos_x(pipe2_pos_x), .pipe3_pos_x(pipe3_pos_x),
    .pipe1_pos_y(pipe1_pos_y), .pipe2_pos_y(pipe2_pos_y), .pipe3_pos_y(pipe3_pos_y),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .layer(layer), .sprite_addr(sprite_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One isolated pixel; result is due three clocks later
  task automatic probe(input string tag, input int x, input int y,
                       input int exp_layer, input int exp_addr);
    pix_valid = 1'b1;
    pix_x     = 16'(x);
    pix_y     = 16'(y);
    tick();
    pix_valid = 1'b0;
    tick();
    chk({tag, "_early"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_vld"},   32'(out_valid), 32'd1);
    chk({tag, "_x"},     32'(out_x), 32'(x));
    chk({tag, "_y"},     32'(out_y), 32'(y));
    chk({tag, "_layer"}, 32'(layer), 32'(exp_layer));
    chk({tag, "_addr"},  32'(sprite_addr), 32'(exp_addr));
    tick();
  endtask

  // Frame pulse followed by enough clocks for the snapshot to land
  task automatic frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic set_pipes(input int x1, input int y1, input int x2, input int y2,
                           input int x3, input int y3);
    pipe1_pos_x = 16'(x1); pipe1_pos_y = 16'(y1);
    pipe2_pos_x = 16'(x2); pipe2_pos_y = 16'(y2);
    pipe3_pos_x = 16'(x3); pipe3_pos_y = 16'(y3);
  endtask

  task automatic set_bird(input int x, input int y, input int st, input int ang);
    bird_pos_x  = 16'(x);
    bird_pos_y  = 16'(y);
    bird_status = 2'(st);
    bird_angle  = 8'(ang);
  endtask

  initial begin
    rstn        = 1'b0;
    new_frame   = 1'b0;
    pix_valid   = 1'b0;
    pix_x       = '0;
    pix_y       = '0;
    stage_shift = '0;
    set_bird(420, 200, 0, 0);
    set_pipes(0, 5000, 0, 5000, 0, 5000);

    // Reset state
    tick(); tick(); tick();
    chk("rst_vld",   32'(out_valid), 32'd0);
    chk("rst_x",     32'(out_x), 32'd0);
    chk("rst_y",     32'(out_y), 32'd0);
    chk("rst_layer", 32'(layer), 32'd0);
    chk("rst_addr",  32'(sprite_addr), 32'd0);
    rstn = 1'b1;
    tick();

    // Snapshot timing: bird moves to 500 one cycle after the pulse
    new_frame = 1'b1;
    tick();
    new_frame  = 1'b0;
    bird_pos_x = 16'sd500;
    tick(); tick(); tick(); tick();
    probe("snap_new", 500, 200, 4, 'h1000);
    probe("snap_old", 420, 200, 0, 0);

    // Priority: bird over the pipe gap
    set_bird(300, 200, 2, 20);
    set_pipes(0, 5000, 400, 190, 0, 5000);
    frame();
    probe("pri_bird", 300, 210, 4, 'hA00A);

    // Bird moved away: caps, body, gap and the half-open bird box
    set_bird(100, 300, 2, 20);
    frame();
    probe("pri_cap_hi", 405, 210, 3, 'h114);
    probe("pri_cap_lo", 200, 210, 3, 'h114);
    probe("pri_body",   430, 210, 2, 20);
    probe("pri_gap",    300, 210, 0, 0);
    probe("bird_edge",  134, 300, 0, 0);
    probe("bird_last",  133, 347, 4, 'hA86F);

    // Ground stripe with stage_shift 27, bird tilted nose-down
    set_bird(1000, 1000, 1, -31);
    set_pipes(0, 5000, 0, 5000, 0, 5000);
    stage_shift = 16'sd27;
    frame();
    probe("gnd_27",    50, 5, 1, 1604);
    probe("tilt_down", 1000, 1000, 4, 'h4000);

    // Negative pipe origins, stage_shift 0, tilt threshold exactly -30
    set_bird(1000, 1000, 1, -30);
    set_pipes(-100, -120, 0, 5000, -100, -200);
    stage_shift = 16'sd0;
    frame();
    probe("gnd_0",      50, 5, 1, 1605);
    probe("neg_body",   10, -20, 2, 100);
    probe("neg_edge",   10, -16, 1, 332);
    probe("low_idx",    10, -100, 2, 20);
    probe("pipe3_only", 10, -150, 2, 50);
    probe("tilt_mid",   1000, 1000, 4, 'h5000);

    // Snapshot change mid-stream must leave stage_shift latched
    stage_shift = 16'sd27;
    probe("no_frame", 50, 5, 1, 1605);

    // Throughput: 10 pixels, 2 bubbles, 3 pixels
    tick();
    vld_seen = 0;
    for (int c = 0; c < 18; c++) begin
      int k;
      logic expv;
      if (c < 15) begin
        pix_valid = (c < 10) || (c >= 12);
        pix_x     = pix_valid ? 16'(200 + c) : 16'sd999;
        pix_y     = pix_valid ? 16'(400 + c) : 16'sd999;
      end else begin
        pix_valid = 1'b0;
      end
      tick();
      k    = c - 2;
      expv = (k >= 0) && (k < 15) && ((k < 10) || (k >= 12));
      if (out_valid) vld_seen++;
      chk($sformatf("tp_vld_%0d", k), 32'(out_valid), 32'(expv));
      if (expv) begin
        chk($sformatf("tp_x_%0d", k), 32'(out_x), 32'(200 + k));
        chk($sformatf("tp_y_%0d", k), 32'(out_y), 32'(400 + k));
      end else if (k == 10 || k == 11) begin
        chk($sformatf("tp_hold_%0d", k), 32'(out_x), 32'd209);
      end
    end
    chk("tp_count", 32'(vld_seen), 32'd13);

    // Reset with three pixels in flight
    pix_valid = 1'b1; pix_x = 16'sd1; pix_y = 16'sd1;
    tick();
    pix_x = 16'sd2; pix_y = 16'sd2;
    tick();
    pix_x = 16'sd3; pix_y = 16'sd3;
    rstn  = 1'b0;
    tick();
    chk("mrst_vld0",  32'(out_valid), 32'd0);
    chk("mrst_x",     32'(out_x), 32'd0);
    chk("mrst_layer", 32'(layer), 32'd0);
    chk("mrst_addr",  32'(sprite_addr), 32'd0);
    rstn      = 1'b1;
    pix_valid = 1'b0;
    tick();
    chk("mrst_vld1", 32'(out_valid), 32'd0);
    tick();
    chk("mrst_vld2", 32'(out_valid), 32'd0);
    tick();
    chk("mrst_vld3", 32'(out_valid), 32'd0);
    probe("mrst_bird0", 0, 0, 4, 'h1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
